// File: rtl/fetch_stage.sv
// Instruction fetch stage: two-cycle boot vector load, then sequential fetch of
// one- and two-word instructions into the IF/ID register with stall/flush/redirect/interrupt.
module fetch_stage #(
    parameter logic [31:0] RESET_VEC_ADDR = 32'h0000_0000,
    parameter logic [15:0] NOP_WORD       = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    output logic        imem_rd,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        flush,
    input  logic        pc_write,
    input  logic [31:0] pc_target,
    input  logic        interrupt,
    output logic [15:0] instruction,
    output logic [31:0] pc_out,
    output logic [15:0] imm_out,
    output logic        imm_valid,
    output logic        interrupt_signal
);

    localparam logic [1:0] ST_BOOT0 = 2'd0;
    localparam logic [1:0] ST_BOOT1 = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_IMM   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [15:0] hold_q, hold_d;
    logic        int_pending_q, int_pending_d;
    logic [15:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [15:0] imm_q, imm_d;
    logic        imm_valid_q, imm_valid_d;
    logic        int_sig_q, int_sig_d;
    logic [31:0] pc_inc;

    function automatic logic is_two_word(input logic [15:0] word);
        return word[15:13] == 3'b110;
    endfunction

    assign pc_inc  = pc_q + 32'd1;
    assign imem_rd = reset;

    always_comb begin
        case (state_q)
            ST_BOOT0: imem_addr = RESET_VEC_ADDR;
            ST_BOOT1: imem_addr = RESET_VEC_ADDR + 32'd1;
            default:  imem_addr = pc_q;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hold_d        = hold_q;
        int_pending_d = int_pending_q;
        instr_d       = instr_q;
        pc_out_d      = pc_out_q;
        imm_d         = imm_q;
        imm_valid_d   = imm_valid_q;
        int_sig_d     = 1'b0;

        case (state_q)
            ST_BOOT0: begin
                pc_d[15:0] = imem_data;
                state_d    = ST_BOOT1;
            end
            ST_BOOT1: begin
                pc_d[31:16] = imem_data;
                state_d     = ST_RUN;
            end
            default: begin
                int_pending_d = int_pending_q | interrupt;
                if (stall) begin
                    // everything frozen; only the pending flag may change
                end else if (pc_write) begin
                    pc_d        = pc_target;
                    instr_d     = NOP_WORD;
                    imm_valid_d = 1'b0;
                    state_d     = ST_RUN;
                end else if (flush) begin
                    instr_d     = NOP_WORD;
                    imm_valid_d = 1'b0;
                end else if (state_q == ST_RUN && int_pending_q) begin
                    // PC is not advanced so decode sees the return address in pc_out
                    instr_d       = NOP_WORD;
                    imm_valid_d   = 1'b0;
                    pc_out_d      = pc_q;
                    int_sig_d     = 1'b1;
                    int_pending_d = interrupt;
                end else if (state_q == ST_RUN) begin
                    pc_d        = pc_inc;
                    imm_valid_d = 1'b0;
                    if (is_two_word(imem_data)) begin
                        hold_d  = imem_data;
                        instr_d = NOP_WORD;
                        state_d = ST_IMM;
                    end else begin
                        instr_d  = imem_data;
                        pc_out_d = pc_inc;
                    end
                end else begin
                    instr_d     = hold_q;
                    imm_d       = imem_data;
                    imm_valid_d = 1'b1;
                    pc_out_d    = pc_inc;
                    pc_d        = pc_inc;
                    state_d     = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_BOOT0;
            pc_q          <= 32'h0;
            hold_q        <= 16'h0;
            int_pending_q <= 1'b0;
            instr_q       <= NOP_WORD;
            pc_out_q      <= 32'h0;
            imm_q         <= 16'h0;
            imm_valid_q   <= 1'b0;
            int_sig_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            hold_q        <= hold_d;
            int_pending_q <= int_pending_d;
            instr_q       <= instr_d;
            pc_out_q      <= pc_out_d;
            imm_q         <= imm_d;
            imm_valid_q   <= imm_valid_d;
            int_sig_q     <= int_sig_d;
        end
    end

    assign instruction      = instr_q;
    assign pc_out           = pc_out_q;
    assign imm_out          = imm_q;
    assign imm_valid        = imm_valid_q;
    assign interrupt_signal = int_sig_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expectations are queued as each cycle is driven
// and compared against the captured DUT outputs at the end of every scenario.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic        imem_rd;
    logic [15:0] imem_data;
    logic        stall;
    logic        flush;
    logic        pc_write;
    logic [31:0] pc_target;
    logic        interrupt;
    logic [15:0] instruction;
    logic [31:0] pc_out;
    logic [15:0] imm_out;
    logic        imm_valid;
    logic        interrupt_signal;

    logic [15:0] mem [0:255];

    typedef struct packed {
        logic [15:0] instr;
        logic [31:0] pc;
        logic [15:0] imm;
        logic        iv;
        logic        is;
        logic        rd;
        logic [31:0] addr;
    } obs_t;

    typedef struct {
        string name;
        obs_t  exp;
        obs_t  mask;
    } sb_t;

    sb_t  expq[$];
    obs_t obsq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    obs_t m_all;
    obs_t m_nopc;

    fetch_stage dut (
        .clk              (clk),
        .reset            (reset),
        .imem_addr        (imem_addr),
        .imem_rd          (imem_rd),
        .imem_data        (imem_data),
        .stall            (stall),
        .flush            (flush),
        .pc_write         (pc_write),
        .pc_target        (pc_target),
        .interrupt        (interrupt),
        .instruction      (instruction),
        .pc_out           (pc_out),
        .imm_out          (imm_out),
        .imm_valid        (imm_valid),
        .interrupt_signal (interrupt_signal)
    );

    assign imem_data = mem[imem_addr[7:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t mk(input logic [15:0] instr, input logic [31:0] pc,
                                input logic [15:0] imm, input logic iv, input logic is,
                                input logic rd, input logic [31:0] addr);
        obs_t o;
        o.instr = instr; o.pc = pc; o.imm = imm; o.iv = iv; o.is = is; o.rd = rd; o.addr = addr;
        return o;
    endfunction

    function automatic obs_t snap();
        return mk(instruction, pc_out, imm_out, imm_valid, interrupt_signal, imem_rd, imem_addr);
    endfunction

    // Record an expectation for the current (unclocked) state.
    task automatic look(input string name, input obs_t exp, input obs_t mask);
        expq.push_back('{name, exp, mask});
        obsq.push_back(snap());
    endtask

    // Drive one cycle of inputs, queue the post-edge expectation, capture after the edge.
    task automatic tick(input string name, input logic st, input logic fl, input logic pw,
                        input logic [31:0] tgt, input logic it, input obs_t exp, input obs_t mask);
        stall = st; flush = fl; pc_write = pw; pc_target = tgt; interrupt = it;
        expq.push_back('{name, exp, mask});
        @(posedge clk);
        #1;
        obsq.push_back(snap());
        stall = 1'b0; flush = 1'b0; pc_write = 1'b0; interrupt = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        look("reset_state", mk(16'h0, 32'h0, 16'h0, 0, 0, 0, 32'h0), m_all);
        while (expq.size() > 0) begin
            sb_t e; obs_t o;
            e = expq.pop_front(); o = obsq.pop_front(); n_cmp++;
            if ((o & e.mask) !== (e.exp & e.mask)) begin
                n_err++;
                $display("FAIL %s: actual %h required %h", e.name, o & e.mask, e.exp & e.mask);
            end
        end
    endtask

    task automatic test_boot();
        reset = 1'b1;
        #1;
        look("boot0_addr", mk(16'h0, 32'h0, 16'h0, 0, 0, 1, 32'h0), m_all);
        tick("boot1_addr", 0, 0, 0, 0, 0, mk(16'h0, 32'h0, 16'h0, 0, 0, 1, 32'h1), m_all);
        tick("boot_run_addr", 1, 1, 1, 32'h77, 1, mk(16'h0, 32'h0, 16'h0, 0, 0, 1, 32'h10), m_all);
        tick("first_instr", 0, 0, 0, 0, 0, mk(16'h0010, 32'h11, 16'h0, 0, 0, 1, 32'h11), m_all);
        while (expq.size() > 0) begin
            sb_t e; obs_t o;
            e = expq.pop_front(); o = obsq.pop_front(); n_cmp++;
            if ((o & e.mask) !== (e.exp & e.mask)) begin
                n_err++;
                $display("FAIL %s: actual %h required %h", e.name, o & e.mask, e.exp & e.mask);
            end
        end
    endtask

    task automatic test_back_to_back();
        tick("seq_0x11", 0, 0, 0, 0, 0, mk(16'h0011, 32'h12, 16'h0, 0, 0, 1, 32'h12), m_all);
        tick("seq_0x12", 0, 0, 0, 0, 0, mk(16'h0012, 32'h13, 16'h0, 0, 0, 1, 32'h13), m_all);
        while (expq.size() > 0) begin
            sb_t e; obs_t o;
            e = expq.pop_front(); o = obsq.pop_front(); n_cmp++;
            if ((o & e.mask) !== (e.exp & e.mask)) begin
                n_err++;
                $display("FAIL %s: actual %h required %h", e.name, o & e.mask, e.exp & e.mask);
            end
        end
    endtask

    task automatic test_stall();
        tick("redir_0x20", 0, 0, 1, 32'h20, 0, mk(16'h0, 32'h0, 16'h0, 0, 0, 1, 32'h20), m_nopc);
        tick("stall_1", 1, 0, 0, 0, 0, mk(16'h0, 32'h0, 16'h0, 0, 0, 1, 32'h20), m_nopc);
        tick("stall_2_over_pcw", 1, 1, 1, 32'h99, 0, mk(16'h0, 32'h0, 16'h0, 0, 0, 1, 32'h20), m_nopc);
        tick("stall_3", 1, 0, 0, 0, 0, mk(16'h0, 32'h0, 16'h0, 0, 0, 1, 32'h20), m_nopc);
        tick("resume_0x20", 0, 0, 0, 0, 0, mk(16'h0020, 32'h21, 16'h0, 0, 0, 1, 32'h21), m_all);
        while (expq.size() > 0) begin
            sb_t e; obs_t o;
            e = expq.pop_front(); o = obsq.pop_front(); n_cmp++;
            if ((o & e.mask) !== (e.exp & e.mask)) begin
                n_err++;
                $display("FAIL %s: actual %h required %h", e.name, o & e.mask, e.exp & e.mask);
            end
        end
    endtask

    task automatic test_interrupt();
        tick("redir_0x30", 0, 0, 1, 32'h30, 0, mk(16'h0, 32'h0, 16'h0, 0, 0, 1, 32'h30), m_nopc);
        tick("int_during_stall", 1, 0, 0, 0, 1, mk(16'h0, 32'h0, 16'h0, 0, 0, 1, 32'h30), m_nopc);
        tick("int_service", 0, 0, 0, 0, 0, mk(16'h0, 32'h30, 16'h0, 0, 1, 1, 32'h30), m_all);
        tick("after_service", 0, 0, 0, 0, 0, mk(16'h0030, 32'h31, 16'h0, 0, 0, 1, 32'h31), m_all);
        while (expq.size() > 0) begin
            sb_t e; obs_t o;
            e = expq.pop_front(); o = obsq.pop_front(); n_cmp++;
            if ((o & e.mask) !== (e.exp & e.mask)) begin
                n_err++;
                $display("FAIL %s: actual %h required %h", e.name, o & e.mask, e.exp & e.mask);
            end
        end
    endtask

    task automatic test_redirect_imm();
        tick("enter_imm", 0, 0, 0, 0, 0, mk(16'h0, 32'h0, 16'h0, 0, 0, 1, 32'h32), m_nopc);
        tick("redir_in_imm", 0, 0, 1, 32'h40, 0, mk(16'h0, 32'h0, 16'h0, 0, 0, 1, 32'h40), m_nopc);
        tick("run_after_redir", 0, 0, 0, 0, 0, mk(16'h0040, 32'h41, 16'h0, 0, 0, 1, 32'h41), m_all);
        while (expq.size() > 0) begin
            sb_t e; obs_t o;
            e = expq.pop_front(); o = obsq.pop_front(); n_cmp++;
            if ((o & e.mask) !== (e.exp & e.mask)) begin
                n_err++;
                $display("FAIL %s: actual %h required %h", e.name, o & e.mask, e.exp & e.mask);
            end
        end
    endtask

    task automatic test_two_word_flush();
        tick("tw_first", 0, 0, 0, 0, 0, mk(16'h0, 32'h0, 16'h0, 0, 0, 1, 32'h42), m_nopc);
        tick("flush_in_imm", 0, 1, 0, 0, 0, mk(16'h0, 32'h0, 16'h0, 0, 0, 1, 32'h42), m_nopc);
        tick("tw_complete", 0, 0, 0, 0, 0, mk(16'hC155, 32'h43, 16'hABCD, 1, 0, 1, 32'h43), m_all);
        tick("imm_hold", 0, 0, 0, 0, 0, mk(16'h0043, 32'h44, 16'hABCD, 0, 0, 1, 32'h44), m_all);
        tick("flush_in_run", 0, 1, 0, 0, 0, mk(16'h0, 32'h0, 16'hABCD, 0, 0, 1, 32'h44), m_nopc);
        tick("refetch", 0, 0, 0, 0, 0, mk(16'h0044, 32'h45, 16'hABCD, 0, 0, 1, 32'h45), m_all);
        while (expq.size() > 0) begin
            sb_t e; obs_t o;
            e = expq.pop_front(); o = obsq.pop_front(); n_cmp++;
            if ((o & e.mask) !== (e.exp & e.mask)) begin
                n_err++;
                $display("FAIL %s: actual %h required %h", e.name, o & e.mask, e.exp & e.mask);
            end
        end
    endtask

    task automatic test_wrap();
        tick("redir_top", 0, 0, 1, 32'hFFFF_FFFF, 0, mk(16'h0, 32'h0, 16'hABCD, 0, 0, 1, 32'hFFFF_FFFF), m_nopc);
        tick("wrap", 0, 0, 0, 0, 0, mk(16'h00FF, 32'h0, 16'hABCD, 0, 0, 1, 32'h0), m_all);
        while (expq.size() > 0) begin
            sb_t e; obs_t o;
            e = expq.pop_front(); o = obsq.pop_front(); n_cmp++;
            if ((o & e.mask) !== (e.exp & e.mask)) begin
                n_err++;
                $display("FAIL %s: actual %h required %h", e.name, o & e.mask, e.exp & e.mask);
            end
        end
    endtask

    task automatic test_reset_mid_imm();
        mem[16'h10] = 16'hC100;
        mem[16'h11] = 16'h1234;
        tick("redir_0x10", 0, 0, 1, 32'h10, 0, mk(16'h0, 32'h0, 16'hABCD, 0, 0, 1, 32'h10), m_nopc);
        tick("imm_pending", 0, 0, 0, 0, 0, mk(16'h0, 32'h0, 16'hABCD, 0, 0, 1, 32'h11), m_nopc);
        #2 reset = 1'b0;
        #1;
        look("async_reset", mk(16'h0, 32'h0, 16'h0, 0, 0, 0, 32'h0), m_all);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        look("reboot0", mk(16'h0, 32'h0, 16'h0, 0, 0, 1, 32'h0), m_all);
        tick("reboot1", 0, 0, 0, 0, 0, mk(16'h0, 32'h0, 16'h0, 0, 0, 1, 32'h1), m_all);
        tick("reboot_run", 0, 0, 0, 0, 0, mk(16'h0, 32'h0, 16'h0, 0, 0, 1, 32'h10), m_all);
        tick("reboot_tw_nop", 0, 0, 0, 0, 0, mk(16'h0, 32'h0, 16'h0, 0, 0, 1, 32'h11), m_all);
        tick("reboot_tw", 0, 0, 0, 0, 0, mk(16'hC100, 32'h12, 16'h1234, 1, 0, 1, 32'h12), m_all);
        while (expq.size() > 0) begin
            sb_t e; obs_t o;
            e = expq.pop_front(); o = obsq.pop_front(); n_cmp++;
            if ((o & e.mask) !== (e.exp & e.mask)) begin
                n_err++;
                $display("FAIL %s: actual %h required %h", e.name, o & e.mask, e.exp & e.mask);
            end
        end
    endtask

    initial begin
        m_all  = '1;
        m_nopc = mk(16'hFFFF, 32'h0, 16'hFFFF, 1, 1, 1, 32'hFFFF_FFFF);
        for (int i = 0; i < 256; i++) mem[i] = {8'h00, i[7:0]};
        mem[0]     = 16'h0010;
        mem[1]     = 16'h0000;
        mem[16'h31] = 16'hC0AB;
        mem[16'h41] = 16'hC155;
        mem[16'h42] = 16'hABCD;
        stall = 1'b0; flush = 1'b0; pc_write = 1'b0; pc_target = 32'h0; interrupt = 1'b0;
        reset = 1'b1;

        test_reset();
        test_boot();
        test_back_to_back();
        test_stall();
        test_interrupt();
        test_redirect_imm();
        test_two_word_flush();
        test_wrap();
        test_reset_mid_imm();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
